// File: rtl/gp_timer_pkg.sv
// Shared constants for the multi-channel timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gp_timer_pkg;

    // Channel mode encoding carried on the per-channel mode bus.
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Upper bound on channel count supported by the register wrapper.
    localparam int MAX_NCH = 8;

endpackage

// File: rtl/gp_timer_ch.sv
// One timer channel: up-counter, armed state, compare match and sticky flag.
// Latency: flag and counter update on the clk edge that samples the match.
// Backpressure: none; restart and flag_clr are single-cycle pulses.
module gp_timer_ch
    import gp_timer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         en,
    input  logic         mode,
    input  logic         restart,
    input  logic [W-1:0] cmp,
    input  logic         flag_clr,
    output logic [W-1:0] cnt,
    output logic         flag,
    output logic         active
);

    logic match;

    // A match only counts on a prescaler tick while enabled and armed; a
    // compare value below the counter is reached after the natural wrap.
    assign match = tick & en & active & (cnt == cmp);

    // Counter and armed state: restart beats a match, a match beats counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b1;
        end else if (restart) begin
            cnt    <= '0;
            active <= 1'b1;
        end else if (match && (mode == MODE_PERIODIC)) begin
            cnt    <= '0;
        end else if (match && (mode == MODE_ONESHOT)) begin
            cnt    <= cmp;
            active <= 1'b0;
        end else if (tick && en && active) begin
            cnt    <= cnt + W'(1);
        end
    end

    // Sticky match flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag <= 1'b0;
        end else if (match) begin
            flag <= 1'b1;
        end else if (flag_clr) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/gp_timer.sv
// Multi-channel timer: shared prescaler feeding NCH compare/match channels.
// Latency: flag one cycle after the matching edge, irq one cycle after flag.
// Backpressure: none; configuration buses are level inputs from the bus wrapper.
module gp_timer
    import gp_timer_pkg::*;
#(
    parameter int W   = 32,
    parameter int PW  = 16,
    parameter int NCH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PW-1:0]    pre,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   mode,
    input  logic [NCH-1:0]   restart,
    input  logic [NCH*W-1:0] cmp,
    input  logic [NCH-1:0]   ie,
    input  logic [NCH-1:0]   flag_clr,
    output logic [NCH*W-1:0] cnt,
    output logic [NCH-1:0]   flag,
    output logic [NCH-1:0]   active,
    output logic             irq
);

    logic [PW-1:0] prediv;
    logic          any_en;
    logic          tick;

    assign any_en = |en;
    assign tick   = any_en && (prediv == pre);

    // Prescaler: idles at zero while every channel is disabled, so the first
    // tick after enabling always lands pre+1 cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prediv <= '0;
        end else if (!any_en || tick) begin
            prediv <= '0;
        end else begin
            prediv <= prediv + PW'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gp_timer_ch #(
            .W (W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .en       (en[i]),
            .mode     (mode[i]),
            .restart  (restart[i]),
            .cmp      (cmp[i*W +: W]),
            .flag_clr (flag_clr[i]),
            .cnt      (cnt[i*W +: W]),
            .flag     (flag[i]),
            .active   (active[i])
        );
    end

    // Registered interrupt: any enabled flag raises irq one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(flag & ie);
        end
    end

endmodule

// File: tb/tb_gp_timer.sv
module tb_gp_timer;

    localparam int W   = 8;
    localparam int PW  = 16;
    localparam int NCH = 4;
    localparam int IRQ_ID = NCH;   // scoreboard id used for irq rising edges

    logic             clk = 1'b0;
    logic             rst;
    logic [PW-1:0]    pre;
    logic [NCH-1:0]   en, mode, restart, ie, flag_clr;
    logic [NCH*W-1:0] cmp;
    logic [NCH*W-1:0] cnt;
    logic [NCH-1:0]   flag, active;
    logic             irq;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { int ch; int cyc; } ev_t;
    ev_t exp_q[$];
    logic [NCH:0] prev_out = '0;

    gp_timer #(.W(W), .PW(PW), .NCH(NCH)) dut (
        .clk      (clk),
        .rst      (rst),
        .pre      (pre),
        .en       (en),
        .mode     (mode),
        .restart  (restart),
        .cmp      (cmp),
        .ie       (ie),
        .flag_clr (flag_clr),
        .cnt      (cnt),
        .flag     (flag),
        .active   (active),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rising edge of a flag or of irq must match a queued event.
    always @(negedge clk) begin
        for (int c = 0; c <= NCH; c++) begin
            logic cur;
            int   idx;
            cur = (c < NCH) ? flag[c] : irq;
            if (cur && !prev_out[c]) begin
                idx = -1;
                foreach (exp_q[k])
                    if (idx < 0 && exp_q[k].ch == c && exp_q[k].cyc == cyc) idx = k;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL event: output %0d rose at cycle %0d, no matching expected event", c, cyc);
                end else begin
                    exp_q.delete(idx);
                end
            end
        end
        prev_out <= {irq, flag};
    end

    initial begin
        #60000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] cnt_of(input int c);
        return cnt[c*W +: W];
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push(input int ch, input int t);
        ev_t e;
        e.ch  = ch;
        e.cyc = t;
        exp_q.push_back(e);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        en = '0; mode = '0; restart = '0; ie = '0; flag_clr = '0; cmp = '0; pre = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int t0, t1, r;
        rst = 1'b1;
        pre = '0; en = '0; mode = '0; restart = '0; cmp = '0; ie = '0; flag_clr = '0;
        repeat (2) @(negedge clk);
        chk("reset_cnt",    cnt,    32'h0);
        chk("reset_flag",   flag,   32'h0);
        chk("reset_active", active, 32'hf);
        chk("reset_irq",    irq,    32'h0);
        rst = 1'b0;

        // Periodic: pre=3, cmp0=4 -> 20-cycle period, irq one cycle behind flag.
        reset_dut();
        pre = 16'd3; cmp[7:0] = 8'd4; ie = 4'b0001; en = 4'b0001;
        t0 = cyc;
        push(0, t0 + 20); push(IRQ_ID, t0 + 21);
        push(0, t0 + 40); push(IRQ_ID, t0 + 41);
        for (int k = 1; k <= 5; k++) begin
            wait_until(t0 + 4 * k);
            chk("periodic_cnt_seq", cnt_of(0), (k == 5) ? 32'd0 : 32'(k));
        end
        wait_until(t0 + 25); flag_clr = 4'b0001;
        wait_until(t0 + 26); flag_clr = '0;
        chk("periodic_flag_cleared", flag[0], 32'd0);
        chk("periodic_irq_lag", irq, 32'd1);
        wait_until(t0 + 27);
        chk("periodic_irq_drop", irq, 32'd0);
        wait_until(t0 + 42);
        en = '0;

        // One-shot on channel 1, then switch to periodic while expired, then restart.
        reset_dut();
        cmp[15:8] = 8'd9; mode = 4'b0010; en = 4'b0010;
        t0 = cyc;
        push(1, t0 + 10);
        wait_until(t0 + 9);
        chk("oneshot_cnt_before", cnt_of(1), 32'd9);
        chk("oneshot_active_before", active[1], 32'd1);
        wait_until(t0 + 10);
        chk("oneshot_cnt_hold", cnt_of(1), 32'd9);
        chk("oneshot_active_clr", active[1], 32'd0);
        mode = 4'b0000;
        wait_until(t0 + 14);
        chk("oneshot_stays_expired_cnt", cnt_of(1), 32'd9);
        chk("oneshot_stays_expired_act", active[1], 32'd0);
        wait_until(t0 + 15); restart = 4'b0010;
        wait_until(t0 + 16); restart = '0;
        chk("restart_cnt", cnt_of(1), 32'd0);
        chk("restart_active", active[1], 32'd1);
        wait_until(t0 + 17);
        chk("restart_counts", cnt_of(1), 32'd1);
        en = '0;

        // Flag priority: clear coincident with match loses; a lone clear wins.
        reset_dut();
        cmp[23:16] = 8'd3; ie = 4'b0100; en = 4'b0100;
        t0 = cyc;
        push(2, t0 + 4); push(IRQ_ID, t0 + 5);
        wait_until(t0 + 3); flag_clr = 4'b0100;
        wait_until(t0 + 4); flag_clr = '0;
        chk("prio_set_wins", flag[2], 32'd1);
        wait_until(t0 + 5); en = '0;
        wait_until(t0 + 7); flag_clr = 4'b0100;
        wait_until(t0 + 8); flag_clr = '0;
        chk("prio_clear_alone", flag[2], 32'd0);
        chk("prio_irq_lag", irq, 32'd1);
        wait_until(t0 + 9);
        chk("prio_irq_drop", irq, 32'd0);

        // Wrap-around: cmp lowered below cnt -> run to 255, wrap, match at 50.
        reset_dut();
        cmp[7:0] = 8'd250; en = 4'b0001;
        t0 = cyc;
        wait_until(t0 + 200);
        chk("wrap_cnt_200", cnt_of(0), 32'd200);
        cmp[7:0] = 8'd50;
        push(0, t0 + 307);
        wait_until(t0 + 255);
        chk("wrap_cnt_255", cnt_of(0), 32'd255);
        wait_until(t0 + 256);
        chk("wrap_cnt_0", cnt_of(0), 32'd0);
        chk("wrap_no_flag", flag[0], 32'd0);
        wait_until(t0 + 306);
        chk("wrap_cnt_50", cnt_of(0), 32'd50);
        wait_until(t0 + 307);
        chk("wrap_match_reload", cnt_of(0), 32'd0);
        en = '0;

        // Enable/disable: freeze, then first increment exactly pre+1 cycles after re-enable.
        reset_dut();
        pre = 16'd4; cmp[7:0] = 8'd200; en = 4'b0001;
        t0 = cyc;
        wait_until(t0 + 12);
        chk("endis_cnt_before", cnt_of(0), 32'd2);
        en = '0;
        wait_until(t0 + 20);
        chk("endis_frozen", cnt_of(0), 32'd2);
        en = 4'b0001;
        t1 = cyc;
        wait_until(t1 + 4);
        chk("endis_no_early_tick", cnt_of(0), 32'd2);
        wait_until(t1 + 5);
        chk("endis_first_tick", cnt_of(0), 32'd3);
        en = '0;

        // Four channels concurrently, then asynchronous reset mid-count.
        reset_dut();
        pre = 16'd1;
        cmp = {8'd7, 8'd5, 8'd3, 8'd2};
        ie = 4'b0001; en = 4'b1111;
        t0 = cyc;
        push(0, t0 + 6); push(IRQ_ID, t0 + 7); push(1, t0 + 8);
        push(2, t0 + 12); push(3, t0 + 16);
        wait_until(t0 + 20);
        chk("multi_cnt", cnt, {8'd2, 8'd4, 8'd2, 8'd1});
        chk("multi_flags", flag, 32'hf);
        chk("multi_irq", irq, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cnt", cnt, 32'h0);
        chk("async_rst_flag", flag, 32'h0);
        chk("async_rst_active", active, 32'hf);
        chk("async_rst_irq", irq, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        wait_until(r + 1);
        chk("post_rst_no_tick", cnt, 32'h0);
        wait_until(r + 2);
        chk("post_rst_first_tick", cnt, {8'd1, 8'd1, 8'd1, 8'd1});
        en = '0;

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected events never seen, first ch %0d at cycle %0d",
                     exp_q.size(), exp_q[0].ch, exp_q[0].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gp_timer.md
# gp_timer

Parametrised multi-channel timer, successor to the single 32-bit prescaled timer. One shared prescaler drives NCH independent W-bit up-counters. Each channel has its own compare value, periodic or one-shot mode, sticky match flag with clear, and interrupt enable. Sits behind the peripheral bus register wrapper, which drives the flat configuration buses; `irq` goes to the interrupt controller.

## Interface
- W, 32, counter and compare width (2..32)
- PW, 16, prescaler width
- NCH, 4, number of channels (1..8)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pre  in  PW  prescaler value; tick period = pre+1 clk cycles
- en  in  NCH  per-channel count enable
- mode  in  NCH  per-channel mode: 0 periodic, 1 one-shot
- restart  in  NCH  per-channel pulse: counter to 0, re-arm
- cmp  in  NCH*W  compare values; channel i uses bits [i*W +: W]
- ie  in  NCH  per-channel interrupt enable
- flag_clr  in  NCH  per-channel pulse: clear match flag
- cnt  out  NCH*W  counter values; channel i uses bits [i*W +: W]
- flag  out  NCH  sticky match flags
- active  out  NCH  1 = channel armed (one-shot not yet expired)
- irq  out  1  OR over i of (flag[i] & ie[i]), registered

## Operation
- Prescaler: `prediv` (PW bits). If en == 0: prediv <= 0, no tick. Otherwise, when prediv == pre: tick = 1 and prediv <= 0; else prediv <= prediv + 1. tick is combinational from prediv and pre.
- Channel match event: match_i = tick & en[i] & active[i] & (cnt_i == cmp_i).
- Channel counter priority, highest first:
  1. restart[i]: cnt_i <= 0, active[i] <= 1.
  2. match_i, periodic mode: cnt_i <= 0.
  3. match_i, one-shot mode: cnt_i holds at cmp_i, active[i] <= 0.
  4. tick & en[i] & active[i]: cnt_i <= cnt_i + 1, modulo 2^W.
  5. Otherwise: hold.
- Flag: match_i sets flag[i]. Otherwise flag_clr[i] clears it. Simultaneous set and clear: set wins, so no event is lost.
- Periodic period = (cmp_i+1)*(pre+1) clk cycles when en is continuously high.
- cmp_i written below the current cnt_i: the counter runs up to 2^W-1, wraps to 0, and matches on the next pass. No match is generated at the wrap itself.
- A mode change mid-count takes effect at the next match. An expired one-shot stays inactive until restart, even if mode is switched to periodic.
- en[i] low freezes cnt_i and active[i]; flag is unaffected.

## Timing
- Reset values: cnt = 0, flag = 0, active = all ones, irq = 0, prediv = 0.
- flag[i] is high the cycle after the clk edge that samples match_i.
- irq lags flag by 1 cycle.
- cmp = 0 in periodic mode: match on every tick, cnt stays 0.
- pre = 0: tick on every cycle while any en bit is set.
- Reset asserted mid-count returns all state to reset values asynchronously. The first tick after reset release comes pre+1 cycles after en goes high.
- restart in the same cycle as a match: restart wins for cnt and active. The flag is still set.

## Structure
- Package gp_timer_pkg holds:
  - the mode encoding constants MODE_PERIODIC = 1'b0 and MODE_ONESHOT = 1'b1;
  - the MAX_NCH = 8 limit.
- Sub-module gp_timer_ch holds one channel: counter, active, flag, match logic, parameter W. Instantiate it NCH times in a generate loop.
- The prescaler and irq OR-reduction stay in the top level.

## Test plan
- Periodic period: pre=3, cmp0=4, en=0001, mode=0 -> flag[0] rises every 20 cycles; cnt0 sequence 0..4,0; with ie[0]=1, irq follows flag by 1 cycle.
- One-shot: pre=0, cmp1=9, mode[1]=1, en=0010 -> flag[1] rises after 10 ticks, cnt1 holds at 9, active[1]=0; restart[1] pulse -> cnt1=0, active[1]=1, counting resumes.
- Flag priority: flag_clr[2] asserted in the same cycle as match_2 -> flag[2] stays 1; a later flag_clr alone -> flag[2]=0, irq drops 1 cycle later.
- Wrap-around: W=8, cnt0=200, cmp0 changed to 50 -> cnt0 counts to 255, wraps to 0, flag[0] rises at 50; no flag at the wrap.
- Enable/disable: en cleared mid-count -> cnt frozen and prediv=0; re-enable -> first increment exactly pre+1 cycles later.
- Reset mid-operation: rst asserted asynchronously between clock edges -> all outputs return to reset values immediately; four channels running concurrently with different cmp values each flag at their own periods.
